// File: rtl/pgm_burst.sv
// pgm_burst: replays a stored packet template as a burst of packets,
// with optional sequence stamping, idle gaps, back-pressure and stop.
module pgm_burst #(
  parameter int DATA_W = 134,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8,
  parameter bit SEQ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tpl_data,
  input  logic              tpl_wr,
  output logic              tpl_ready,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  input  logic              in_alf,
  output logic              out_sent_start_flag,
  output logic              out_sent_finish_flag,
  output logic              out_busy,
  output logic [CNT_W-1:0]  out_sent_cnt,
  output logic              tpl_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    tpl_len;
  logic [AW-1:0]    rd_ptr;
  logic             tpl_valid;
  logic             have_head;
  logic             stop_pend;
  logic             inc_pend;
  logic             first;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  logic [1:0]        tag;
  logic              is_head;
  logic              is_mid;
  logic              is_tail;
  logic              tpl_acc;
  logic              tpl_bad;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic              start_ok;
  logic              emit;
  logic [AW-1:0]     idx;
  logic [PW-1:0]     idx_n;
  logic              is_last;
  logic              stop_now;
  logic              burst_end;
  logic [DATA_W-1:0] word;

  assign tpl_ready = (state == IDLE);
  assign out_busy  = (state != IDLE);

  // Template decode, emit qualification and word stamping
  always_comb begin
    tag      = tpl_data[DATA_W-1 -: 2];
    is_head  = (tag == 2'b01);
    is_mid   = (tag == 2'b11);
    is_tail  = (tag == 2'b10);
    tpl_acc  = (state == IDLE) && tpl_wr;
    tpl_bad  = tpl_acc && (is_mid || is_tail) &&
               (!have_head || wr_ptr == PW'(DEPTH));
    mem_we   = tpl_acc &&
               (is_head || ((is_mid || is_tail) && !tpl_bad));
    mem_addr = is_head ? '0 : wr_ptr[AW-1:0];
    start_ok = (state == IDLE) && cfg_start &&
               tpl_valid && (cfg_count != '0);
    emit     = (start_ok || state == SEND) && !in_alf;
    idx      = start_ok ? '0 : rd_ptr;
    idx_n    = PW'(idx) + PW'(1);
    is_last  = (idx_n == tpl_len);
    stop_now = stop_pend || cfg_stop;
    burst_end = ((out_sent_cnt + CNT_W'(1)) == cnt_q) || stop_now;
    word     = mem[idx];
    if (SEQ_EN && idx == AW'(1)) begin
      word[CNT_W-1:0] = out_sent_cnt;
    end
  end

  // Template storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= tpl_data;
    end
  end

  // Burst state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      wr_ptr               <= '0;
      tpl_len              <= '0;
      rd_ptr               <= '0;
      tpl_valid            <= 1'b0;
      have_head            <= 1'b0;
      stop_pend            <= 1'b0;
      inc_pend             <= 1'b0;
      first                <= 1'b0;
      cnt_q                <= '0;
      gap_q                <= '0;
      gap_cnt              <= '0;
      tpl_err              <= 1'b0;
      out_data             <= '0;
      out_data_wr          <= 1'b0;
      out_valid            <= 1'b0;
      out_valid_wr         <= 1'b0;
      out_sent_start_flag  <= 1'b0;
      out_sent_finish_flag <= 1'b0;
      out_sent_cnt         <= '0;
    end else begin
      out_data_wr          <= 1'b0;
      out_valid            <= 1'b0;
      out_valid_wr         <= 1'b0;
      out_sent_start_flag  <= 1'b0;
      out_sent_finish_flag <= 1'b0;
      inc_pend             <= 1'b0;
      if (inc_pend) begin
        out_sent_cnt <= out_sent_cnt + CNT_W'(1);
      end
      if (emit) begin
        out_data            <= word;
        out_data_wr         <= 1'b1;
        out_sent_start_flag <= first || start_ok;
        first               <= 1'b0;
        if (is_last) begin
          out_valid    <= 1'b1;
          out_valid_wr <= 1'b1;
          inc_pend     <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (tpl_acc) begin
            if (is_head) begin
              wr_ptr    <= PW'(1);
              tpl_valid <= 1'b0;
              tpl_err   <= 1'b0;
              have_head <= 1'b1;
            end else if (tpl_bad) begin
              tpl_err   <= 1'b1;
              tpl_valid <= 1'b0;
              have_head <= 1'b0;
            end else if (is_mid) begin
              wr_ptr <= wr_ptr + PW'(1);
            end else if (is_tail) begin
              wr_ptr    <= wr_ptr + PW'(1);
              tpl_len   <= wr_ptr + PW'(1);
              tpl_valid <= 1'b1;
              have_head <= 1'b0;
            end
          end
          if (start_ok) begin
            cnt_q        <= cfg_count;
            gap_q        <= cfg_gap;
            out_sent_cnt <= '0;
            stop_pend    <= 1'b0;
            first        <= !emit;
            rd_ptr       <= emit ? AW'(1) : '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
          if (emit) begin
            if (is_last) begin
              rd_ptr <= '0;
              if (burst_end) begin
                state <= DONE;
              end else if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        GAP: begin
          if (stop_now) begin
            state <= DONE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          out_sent_finish_flag <= 1'b1;
          stop_pend            <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_burst.sv
// tb_pgm_burst: directed and randomized bursts checked every cycle
// against a packet-level reference model of the generator.
module tb_pgm_burst;

  localparam int DW = 134;
  localparam int DP = 4;
  localparam int CW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tpl_data = '0;
  logic          tpl_wr = 1'b0;
  logic          tpl_ready;
  logic [CW-1:0] cfg_count = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_data_wr;
  logic          out_valid;
  logic          out_valid_wr;
  logic          in_alf = 1'b0;
  logic          out_sent_start_flag;
  logic          out_sent_finish_flag;
  logic          out_busy;
  logic [CW-1:0] out_sent_cnt;
  logic          tpl_err;

  pgm_burst #(
    .DATA_W(DW),
    .DEPTH (DP),
    .CNT_W (CW),
    .GAP_W (GW),
    .SEQ_EN(1'b1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .tpl_data            (tpl_data),
    .tpl_wr              (tpl_wr),
    .tpl_ready           (tpl_ready),
    .cfg_count           (cfg_count),
    .cfg_gap             (cfg_gap),
    .cfg_start           (cfg_start),
    .cfg_stop            (cfg_stop),
    .out_data            (out_data),
    .out_data_wr         (out_data_wr),
    .out_valid           (out_valid),
    .out_valid_wr        (out_valid_wr),
    .in_alf              (in_alf),
    .out_sent_start_flag (out_sent_start_flag),
    .out_sent_finish_flag(out_sent_finish_flag),
    .out_busy            (out_busy),
    .out_sent_cnt        (out_sent_cnt),
    .tpl_err             (tpl_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] tq[$];
  logic [DW-1:0] tpl[$];
  bit            t_open = 0;
  bit            t_ok = 0;
  bit            t_errm = 0;
  int            phase = 0;
  int            widx = 0;
  int            idle = 0;
  bit            stp = 0;
  bit            fst = 0;
  bit            cpend = 0;
  logic [CW-1:0] mcount = '0;
  logic [GW-1:0] mgap = '0;
  logic [CW-1:0] e_cnt = '0;
  logic [DW-1:0] e_data = '0;
  bit            e_wr = 0;
  bit            e_vld = 0;
  bit            e_sf = 0;
  bit            e_ff = 0;

  task automatic mreset();
    t_open = 0; t_ok = 0; t_errm = 0;
    phase = 0; widx = 0; idle = 0;
    stp = 0; fst = 0; cpend = 0;
    e_cnt = '0; e_wr = 0; e_vld = 0;
    e_sf = 0; e_ff = 0;
  endtask

  task automatic send_word(logic [CW-1:0] c0);
    logic [DW-1:0] w;
    if (!in_alf) begin
      w = tpl[widx];
      if (widx == 1) w[CW-1:0] = c0;
      e_data = w;
      e_wr = 1;
      e_sf = fst;
      fst = 0;
      if (widx == tpl.size() - 1) begin
        e_vld = 1;
        cpend = 1;
        widx = 0;
        if (c0 + 16'd1 == mcount || stp) phase = 3;
        else if (mgap != 0) begin
          phase = 2;
          idle = int'(mgap);
        end
      end else widx++;
    end
  endtask

  task automatic mstep();
    logic [CW-1:0] c0;
    logic [1:0] tg;
    c0 = e_cnt;
    e_wr = 0; e_vld = 0; e_sf = 0; e_ff = 0;
    if (cpend) begin
      e_cnt = e_cnt + 16'd1;
      cpend = 0;
    end
    case (phase)
      0: begin
        if (cfg_start && t_ok && cfg_count != 0) begin
          phase = 1; widx = 0; e_cnt = '0;
          stp = 0; fst = 1;
          mcount = cfg_count; mgap = cfg_gap;
          send_word(c0);
        end
        if (tpl_wr) begin
          tg = tpl_data[DW-1 -: 2];
          if (tg == 2'b01) begin
            tq.delete();
            tq.push_back(tpl_data);
            t_open = 1; t_ok = 0; t_errm = 0;
          end else if (tg == 2'b11 || tg == 2'b10) begin
            if (!t_open || tq.size() == DP) begin
              t_errm = 1; t_ok = 0; t_open = 0;
            end else begin
              tq.push_back(tpl_data);
              if (tg == 2'b10) begin
                t_ok = 1; t_open = 0; tpl = tq;
              end
            end
          end
        end
      end
      1: begin
        if (cfg_stop) stp = 1;
        send_word(c0);
      end
      2: begin
        if (stp || cfg_stop) phase = 3;
        else begin
          idle--;
          if (idle == 0) phase = 1;
        end
      end
      default: begin
        e_ff = 1;
        phase = 0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else mstep();
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    cmp("busy", DW'(out_busy), DW'(phase != 0));
    cmp("ready", DW'(tpl_ready), DW'(phase == 0));
    cmp("data_wr", DW'(out_data_wr), DW'(e_wr));
    if (e_wr) cmp("data", out_data, e_data);
    cmp("valid", DW'(out_valid), DW'(e_vld));
    cmp("valid_wr", DW'(out_valid_wr), DW'(e_vld));
    cmp("start_flag", DW'(out_sent_start_flag), DW'(e_sf));
    cmp("finish_flag", DW'(out_sent_finish_flag), DW'(e_ff));
    cmp("sent_cnt", DW'(out_sent_cnt), DW'(e_cnt));
    cmp("tpl_err", DW'(tpl_err), DW'(t_errm));
  end

  // ---------------- activity monitor ----------------
  logic [DW-1:0] wq[$];
  int            wcyc[$];
  int            cyc = 0;
  int            nv = 0;
  int            ns = 0;
  int            nf = 0;
  int            ns_cyc = 0;
  int            fin_cyc = 0;
  int            tail_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_data_wr) begin
        wq.push_back(out_data);
        wcyc.push_back(cyc);
      end
      if (out_valid_wr) begin
        nv++;
        tail_cyc = cyc;
      end
      if (out_sent_start_flag) begin
        ns++;
        ns_cyc = cyc;
      end
      if (out_sent_finish_flag) begin
        nf++;
        fin_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] T[$];

  function automatic logic [DW-1:0] mkw(logic [1:0] tg);
    logic [DW-1:0] w;
    w = {tg, 4'($urandom), $urandom, $urandom,
         $urandom, $urandom};
    return w;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic put(logic [DW-1:0] w);
    tpl_data = w;
    tpl_wr = 1;
    tick();
    tpl_wr = 0;
  endtask

  task automatic load(int len);
    T.delete();
    T.push_back(mkw(2'b01));
    for (int i = 1; i < len - 1; i++) T.push_back(mkw(2'b11));
    T.push_back(mkw(2'b10));
    foreach (T[i]) put(T[i]);
  endtask

  task automatic start(int cnt, int gap);
    cfg_count = CW'(cnt);
    cfg_gap = GW'(gap);
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic wait_idle(string n);
    int k;
    k = 0;
    while (out_busy && k < 400) begin
      tick();
      k++;
    end
    cmp({n, "_idle"}, DW'(out_busy), DW'(0));
  endtask

  task automatic clr();
    wq.delete();
    wcyc.delete();
    nv = 0; ns = 0; nf = 0;
  endtask

  initial begin
    logic [DW-1:0] tmp;
    #3;
    cmp("rst_ready", DW'(tpl_ready), DW'(1));
    cmp("rst_busy", DW'(out_busy), DW'(0));
    cmp("rst_wr", DW'(out_data_wr), DW'(0));
    cmp("rst_cnt", DW'(out_sent_cnt), DW'(0));
    tick(2);
    rst_n = 1;
    tick(2);

    // 4-word template, 3 packets back to back
    load(4);
    clr();
    start(3, 0);
    wait_idle("b3");
    cmp("b3_words", DW'(wq.size()), DW'(12));
    if (wq.size() == 12) begin
      cmp("b3_contig", DW'(wcyc[11] - wcyc[0]), DW'(11));
      cmp("b3_sflag_cyc", DW'(ns_cyc), DW'(wcyc[0]));
      cmp("b3_w0", wq[0], T[0]);
      cmp("b3_w7", wq[7], T[3]);
      for (int p = 0; p < 3; p++) begin
        tmp = T[1];
        tmp[CW-1:0] = CW'(p);
        cmp("b3_stamp", wq[4*p+1], tmp);
      end
    end
    cmp("b3_nv", DW'(nv), DW'(3));
    cmp("b3_ns", DW'(ns), DW'(1));
    cmp("b3_nf", DW'(nf), DW'(1));
    cmp("b3_fin", DW'(fin_cyc - tail_cyc), DW'(1));
    cmp("b3_cnt", DW'(out_sent_cnt), DW'(3));
    tick(2);

    // gap of 5 idle cycles
    clr();
    start(2, 5);
    wait_idle("g5");
    cmp("g5_words", DW'(wq.size()), DW'(8));
    if (wq.size() == 8)
      cmp("g5_gap", DW'(wcyc[4] - wcyc[3] - 1), DW'(5));
    cmp("g5_cnt", DW'(out_sent_cnt), DW'(2));
    tick(2);

    // 3-cycle back-pressure inside a packet
    clr();
    start(1, 0);
    tick();
    in_alf = 1;
    tick(3);
    in_alf = 0;
    wait_idle("alf");
    cmp("alf_words", DW'(wq.size()), DW'(4));
    if (wq.size() == 4) begin
      cmp("alf_span", DW'(wcyc[3] - wcyc[0]), DW'(6));
      tmp = T[1];
      tmp[CW-1:0] = '0;
      cmp("alf_w1", wq[1], tmp);
      cmp("alf_w2", wq[2], T[2]);
      cmp("alf_w3", wq[3], T[3]);
    end
    tick(2);

    // graceful stop during the second packet
    clr();
    start(10, 2);
    for (int k = 0; k < 50 && nv == 0; k++) tick();
    tick(3);
    cfg_stop = 1;
    tick();
    cfg_stop = 0;
    wait_idle("stop");
    cmp("stop_nv", DW'(nv), DW'(2));
    cmp("stop_nf", DW'(nf), DW'(1));
    cmp("stop_cnt", DW'(out_sent_cnt), DW'(2));
    cmp("stop_words", DW'(wq.size()), DW'(8));
    tick(2);

    // start with count 0 is ignored
    clr();
    start(0, 0);
    tick();
    cmp("c0_busy", DW'(out_busy), DW'(0));
    cmp("c0_ns", DW'(ns), DW'(0));

    // asynchronous reset in the middle of a burst
    clr();
    start(10, 0);
    tick(3);
    #2;
    rst_n = 0;
    #1;
    cmp("arst_busy", DW'(out_busy), DW'(0));
    cmp("arst_wr", DW'(out_data_wr), DW'(0));
    cmp("arst_ready", DW'(tpl_ready), DW'(1));
    cmp("arst_cnt", DW'(out_sent_cnt), DW'(0));
    tick(2);
    rst_n = 1;
    tick(2);
    cmp("arst_nf", DW'(nf), DW'(0));
    clr();
    start(3, 0);
    tick();
    cmp("arst_start_busy", DW'(out_busy), DW'(0));
    cmp("arst_start_ns", DW'(ns), DW'(0));

    // template overflow
    put(mkw(2'b01));
    for (int i = 0; i < 4; i++) put(mkw(2'b11));
    tick();
    cmp("ovf_err", DW'(tpl_err), DW'(1));
    clr();
    start(1, 0);
    tick();
    cmp("ovf_ns", DW'(ns), DW'(0));
    cmp("ovf_busy", DW'(out_busy), DW'(0));
    load(3);
    cmp("ovf_clear", DW'(tpl_err), DW'(0));
    clr();
    start(2, 1);
    wait_idle("ovf");
    cmp("ovf_nv", DW'(nv), DW'(2));
    tick(2);

    // randomized bursts
    for (int b = 0; b < 30; b++) begin
      if (b == 0 || $urandom_range(0, 2) == 0) begin
        load($urandom_range(2, 4));
        if ($urandom_range(0, 7) == 0) put(mkw(2'b11));
      end
      in_alf = ($urandom_range(0, 3) == 0);
      start($urandom_range(0, 4), $urandom_range(0, 3));
      for (int k = 0; k < 300 && out_busy; k++) begin
        in_alf = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) cfg_stop = 1;
        if ($urandom_range(0, 9) == 0) begin
          tpl_data = mkw(2'($urandom));
          tpl_wr = 1;
        end
        if ($urandom_range(0, 14) == 0) cfg_start = 1;
        tick();
        cfg_stop = 0;
        tpl_wr = 0;
        cfg_start = 0;
      end
      in_alf = 0;
      cmp("rand_idle", DW'(out_busy), DW'(0));
      tick(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
